// File: rtl/gray_seq_monitor.sv
// gray_seq_monitor
//   Watches the Gray-coded count stream from an upstream counter. It registers
//   each valid sample as binary and classifies the step from the previous
//   sample as up, down, hold or illegal. It also tracks lock and keeps
//   saturating error statistics.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   gray_in, gray_valid   Gray sample and its qualifier
//   resync                upstream reload: the next valid sample is a new base
//   clr_err               clears err_sticky / err_count
//   bin_out, bin_valid    binary form of last accepted sample, 1-cycle pulse
//   step_up/down, hold    step classification, qualified by bin_valid
//   err                   1-cycle pulse on an illegal step
//   err_sticky, err_count sticky flag and saturating illegal-step count
//   locked                a base is established and lock has not been lost
module gray_seq_monitor #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned ERR_CNT_W  = 8,
    parameter int unsigned LOSS_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 gray_valid,
    input  logic                 resync,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 bin_valid,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 hold,
    output logic                 err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 locked
);

    // The consecutive-miss counter only has to hold 0..LOSS_LIMIT-1 because
    // reaching the limit clears it.
    localparam int unsigned   CW        = (LOSS_LIMIT < 2) ? 1 : $clog2(LOSS_LIMIT);
    localparam logic [CW-1:0] LAST_MISS = CW'(LOSS_LIMIT - 1);

    typedef enum logic {UNLOCKED, TRACK} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     bin_q, bin_d;
    logic                 bin_valid_q, bin_valid_d;
    logic                 step_up_q, step_up_d;
    logic                 step_down_q, step_down_d;
    logic                 hold_q, hold_d;
    logic                 err_q, err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [CW-1:0]        consec_q, consec_d;

    logic [WIDTH-1:0]     bin_conv;
    logic [WIDTH-1:0]     diff;
    logic                 take_base;
    logic                 is_up, is_down, is_hold;
    logic                 illegal;
    logic                 loss;

    // Gray-to-binary conversion and step classification. bin_q doubles as
    // the previous-value register since it always holds the last sample.
    always_comb begin
        bin_conv            = '0;
        bin_conv[WIDTH-1]   = gray_in[WIDTH-1];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            bin_conv[WIDTH-1-i] = bin_conv[WIDTH-i] ^ gray_in[WIDTH-1-i];
        end
        diff      = bin_conv - bin_q;
        take_base = gray_valid && (resync || (state_q == UNLOCKED));
        is_up     = (diff == WIDTH'(1));
        is_down   = (diff == '1);
        is_hold   = (diff == '0);
        illegal   = gray_valid && !take_base && !(is_up || is_down || is_hold);
        loss      = illegal && (consec_q == LAST_MISS);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (take_base) begin
            state_d = TRACK;
        end else if (loss) begin
            state_d = UNLOCKED;
        end else if (resync && !gray_valid) begin
            state_d = UNLOCKED;
        end
    end

    // Datapath next values
    always_comb begin
        bin_d        = bin_q;
        bin_valid_d  = 1'b0;
        step_up_d    = 1'b0;
        step_down_d  = 1'b0;
        hold_d       = 1'b0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;
        consec_d     = consec_q;

        // Clear first so a same-cycle error counts from zero.
        if (clr_err) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end

        if (gray_valid) begin
            bin_d       = bin_conv;
            bin_valid_d = 1'b1;
            if (take_base) begin
                consec_d = '0;
            end else if (illegal) begin
                err_d        = 1'b1;
                err_sticky_d = 1'b1;
                if (err_count_d != '1) begin
                    err_count_d = err_count_d + ERR_CNT_W'(1);
                end
                consec_d = loss ? '0 : consec_q + CW'(1);
            end else begin
                step_up_d   = is_up;
                step_down_d = is_down;
                hold_d      = is_hold;
                consec_d    = '0;
            end
        end else if (resync) begin
            consec_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q        <= '0;
            bin_valid_q  <= 1'b0;
            step_up_q    <= 1'b0;
            step_down_q  <= 1'b0;
            hold_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            consec_q     <= '0;
        end else begin
            bin_q        <= bin_d;
            bin_valid_q  <= bin_valid_d;
            step_up_q    <= step_up_d;
            step_down_q  <= step_down_d;
            hold_q       <= hold_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            consec_q     <= consec_d;
        end
    end

    // Output logic
    always_comb begin
        bin_out    = bin_q;
        bin_valid  = bin_valid_q;
        step_up    = step_up_q;
        step_down  = step_down_q;
        hold       = hold_q;
        err        = err_q;
        err_sticky = err_sticky_q;
        err_count  = err_count_q;
        locked     = (state_q == TRACK);
    end

endmodule
